skid_reg_stage: RTL

SKID_REG_STAGE -- requirements
Module: skid_reg_stage

---
 rtl/skid_reg_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/skid_reg_stage.sv
// Two-entry skid buffer (head + skid register) with registered FULL_N/EMPTY_N.
// Optional sticky illegal-request flag ERR when SKID_REG_STAGE_ERRCHK_EN is defined.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no entries held, Q_OUT stale
// ONE   | head holds the only entry
// TWO   | head holds oldest entry, skid holds newest
module skid_reg_stage #(
  parameter int unsigned           width = 1,
  parameter logic [width-1:0]      init  = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [width-1:0] D_IN,
  input  logic             ENQ,
  output logic             FULL_N,
  output logic [width-1:0] Q_OUT,
  output logic             EMPTY_N,
  input  logic             DEQ
`ifdef SKID_REG_STAGE_ERRCHK_EN
  ,
  output logic             ERR
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] skid_q, skid_d;
  logic             full_n_q, full_n_d;
  logic             empty_n_q, empty_n_d;
  logic             enq_ok, deq_ok;

  // Requests are qualified only by the registered flags, so no ENQ/DEQ path reaches them.
  assign enq_ok = ENQ & full_n_q;
  assign deq_ok = DEQ & empty_n_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (enq_ok) begin
          head_d  = D_IN;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (enq_ok && deq_ok) begin
          head_d = D_IN;
        end else if (enq_ok) begin
          skid_d  = D_IN;
          state_d = ST_TWO;
        end else if (deq_ok) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deq_ok) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    full_n_d  = (state_d != ST_TWO);
    empty_n_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_EMPTY;
      head_q    <= init;
      skid_q    <= init;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  assign FULL_N  = full_n_q;
  assign EMPTY_N = empty_n_q;
  assign Q_OUT   = head_q;

`ifdef SKID_REG_STAGE_ERRCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (ENQ & ~full_n_q) | (DEQ & ~empty_n_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`endif

endmodule
